// File: rtl/tile_pkg.sv
// Shared constants, types and address helper for the background tile ROM arbiter.
package tile_pkg;

  localparam int TILE_W = 96;   // tile width in texels
  localparam int TILE_H = 96;   // tile height in texels
  localparam int SCR_W  = 640;  // active screen width in pixels
  localparam int SCR_H  = 480;  // active screen height in lines

  localparam int ADDR_W = 15;   // 96*96 = 9216 texels
  localparam int IDX_W  = 3;    // palette index per texel
  localparam int CALC_W = 17;   // wide enough for DrawX*TILE_W without overflow

  typedef logic [IDX_W-1:0]  tile_idx_t;
  typedef logic [ADDR_W-1:0] rom_addr_t;
  typedef logic [CALC_W-1:0] calc_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } lk_state_t;

  // Row-major texel address; both the video path and the lookup path use it.
  function automatic rom_addr_t texel_addr(calc_t row, calc_t col);
    return rom_addr_t'(row * calc_t'(TILE_W) + col);
  endfunction

endpackage

// File: rtl/tile_rom_arbiter_if.sv
// Game-logic lookup handshake: request with texel coordinates, one-cycle ack with data.
interface tile_rom_arbiter_if;
  import tile_pkg::*;

  logic      lk_req;
  logic [6:0] lk_x;
  logic [6:0] lk_y;
  logic      lk_ack;
  tile_idx_t lk_data;

  // Requester side (game logic).
  modport master (
    output lk_req, lk_x, lk_y,
    input  lk_ack, lk_data
  );

  // Arbiter side.
  modport slave (
    input  lk_req, lk_x, lk_y,
    output lk_ack, lk_data
  );

endinterface

// File: rtl/tile_addr_gen.sv
// Screen-to-texel scaling with horizontal scroll wrap, producing the video ROM address.
module tile_addr_gen
  import tile_pkg::*;
(
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic [6:0] scroll,
  output rom_addr_t  video_addr
);

  calc_t col_scaled;
  calc_t col_sum;
  calc_t col_wrapped;
  calc_t row_scaled;

  // Scale pixel coordinates down to texels, then shift by the scroll and wrap once.
  always_comb begin
    col_scaled  = (calc_t'(draw_x) * calc_t'(TILE_W)) / calc_t'(SCR_W);
    col_sum     = col_scaled + calc_t'(scroll);
    col_wrapped = (col_sum >= calc_t'(TILE_W)) ? col_sum - calc_t'(TILE_W) : col_sum;
    row_scaled  = (calc_t'(draw_y) * calc_t'(TILE_H)) / calc_t'(SCR_H);
    video_addr  = texel_addr(row_scaled, col_wrapped);
  end

endmodule

// File: rtl/tile_rom_arbiter.sv
// Shares the tile ROM read port between video scan-out (priority while visible)
// and game-logic lookups (served only during blanking).
module tile_rom_arbiter
  import tile_pkg::*;
(
  input  logic          vga_clk,
  input  logic          reset_n,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          blank,
  input  logic [6:0]    scroll_x,
  output rom_addr_t     rom_address,
  input  tile_idx_t     rom_q,
  output tile_idx_t     pix_index,
  output logic          pix_valid,
  tile_rom_arbiter_if.slave lk
);

  logic [6:0] scroll_q;
  logic       blank_d1;
  rom_addr_t  video_addr;
  rom_addr_t  lk_addr;
  rom_addr_t  rom_addr_d;
  logic       lk_out_of_range;
  logic       lk_issue;
  lk_state_t  state_q;
  lk_state_t  state_d;
  logic       lk_ack_q;
  logic       lk_ack_d;
  tile_idx_t  lk_data_q;
  tile_idx_t  lk_data_d;

  tile_addr_gen u_addr_gen (
    .draw_x     (DrawX),
    .draw_y     (DrawY),
    .scroll     (scroll_q),
    .video_addr (video_addr)
  );

  assign lk_addr         = texel_addr(calc_t'(lk.lk_y), calc_t'(lk.lk_x));
  assign lk_out_of_range = (lk.lk_x >= 7'(TILE_W)) || (lk.lk_y >= 7'(TILE_H));

  // Scroll is sampled once per frame, at the first blank line, so a frame never tears.
  // NOTE: sequential state always uses <= so every register sees pre-edge values.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      scroll_q <= '0;
    end else if (DrawX == 10'd0 && DrawY == 10'(SCR_H)) begin
      scroll_q <= scroll_x;
    end
  end

  // Video pipeline: address registered at N+1, ROM data captured at N+2.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      blank_d1  <= 1'b0;
      pix_valid <= 1'b0;
      pix_index <= '0;
    end else begin
      blank_d1  <= blank;
      pix_valid <= blank_d1;
      pix_index <= blank_d1 ? rom_q : '0;
    end
  end

  // Lookup FSM next state and port arbitration; video always wins while blank is high.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    lk_issue  = 1'b0;
    lk_ack_d  = 1'b0;
    lk_data_d = lk_data_q;

    case (state_q)
      IDLE: begin
        // The !lk_ack_q guard stops a re-issue in the cycle the requester sees its ack.
        if (lk.lk_req && !blank && !lk_ack_q) begin
          if (lk_out_of_range) begin
            lk_ack_d  = 1'b1;
            lk_data_d = '0;
          end else begin
            lk_issue = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Video reclaimed the port: drop the access, the held lk_req retries it later.
        state_d = blank ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        lk_data_d = rom_q;
        lk_ack_d  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rom_addr_d = rom_address;
    if (blank) begin
      rom_addr_d = video_addr;
    end else if (lk_issue) begin
      rom_addr_d = lk_addr;
    end
  end

  // State, ROM address and lookup result registers.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rom_address <= '0;
      lk_ack_q    <= 1'b0;
      lk_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rom_address <= rom_addr_d;
      lk_ack_q    <= lk_ack_d;
      lk_data_q   <= lk_data_d;
    end
  end

  assign lk.lk_ack  = lk_ack_q;
  assign lk.lk_data = lk_data_q;

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Self-checking bench for tile_rom_arbiter: directed table, hand sequences, random vs model.
module tb_tile_rom_arbiter;
  import tile_pkg::*;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic [6:0] scroll_x;
  rom_addr_t  rom_address;
  tile_idx_t  rom_q;
  tile_idx_t  pix_index;
  logic       pix_valid;

  tile_rom_arbiter_if lk_bus ();

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  tile_rom_arbiter dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .scroll_x    (scroll_x),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pix_index   (pix_index),
    .pix_valid   (pix_valid),
    .lk          (lk_bus)
  );

  // ROM contents: a scrambled function of the address; the output reflects rom_address.
  function automatic tile_idx_t rom_model(int a);
    return tile_idx_t'(a ^ (a >> 3) ^ (a >> 6));
  endfunction

  assign rom_q = rom_model(int'(rom_address));

  // Texel address seen by video for a screen pixel under a given scroll.
  function automatic int ref_video(int x, int y, int s);
    return (y * TILE_H / SCR_H) * TILE_W + ((x * TILE_W / SCR_W) + s) % TILE_W;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge vga_clk);
    #1;
  endtask

  typedef struct {
    int dx;
    int dy;
    int exp_addr;
  } vid_vec_t;

  vid_vec_t vtab[6];

  // Random-phase reference state.
  int m_addr, m_pix, m_valid, m_ack, m_data, m_scroll, m_phase, m_lk_addr, m_blank_d1;
  int n_addr, n_pix, n_valid, n_ack, n_data, n_scroll, n_phase, n_lk_addr;

  initial begin
    int prev;

    vtab[0] = '{639, 479, 9215};
    vtab[1] = '{0,   0,   0};
    vtab[2] = '{320, 240, 4656};
    vtab[3] = '{100, 5,   111};
    vtab[4] = '{7,   4,   1};
    vtab[5] = '{633, 470, 9118};

    // ---- Reset with a lookup pending and video active ----
    reset_n = 1'b0;
    DrawX = 10'd0;
    DrawY = 10'd0;
    blank = 1'b1;
    scroll_x = 7'd0;
    lk_bus.lk_req = 1'b1;
    lk_bus.lk_x = 7'd5;
    lk_bus.lk_y = 7'd2;
    repeat (3) step();
    check("reset rom_address", int'(rom_address), 0);
    check("reset pix_index", int'(pix_index), 0);
    check("reset pix_valid", int'(pix_valid), 0);
    check("reset lk_ack", int'(lk_bus.lk_ack), 0);
    check("reset lk_data", int'(lk_bus.lk_data), 0);
    reset_n = 1'b1;
    step();
    check("post-reset lk_ack 1", int'(lk_bus.lk_ack), 0);
    step();
    check("post-reset lk_ack 2", int'(lk_bus.lk_ack), 0);
    lk_bus.lk_req = 1'b0;

    // ---- Video addressing table, scroll 0 ----
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      DrawX = 10'(vtab[i].dx);
      DrawY = 10'(vtab[i].dy);
      step();
      check("video addr", int'(rom_address), vtab[i].exp_addr);
      check("video pix_index", int'(pix_index), int'(rom_model(prev)));
      check("video pix_valid", int'(pix_valid), 1);
      prev = vtab[i].exp_addr;
    end

    // ---- Scroll latch and wrap ----
    blank = 1'b0; DrawX = 10'd0; DrawY = 10'd480; scroll_x = 7'd10;
    step();
    scroll_x = 7'd50;
    blank = 1'b1; DrawX = 10'd600; DrawY = 10'd0;
    step();
    check("scroll wrap addr", int'(rom_address), 4);
    DrawX = 10'd0;
    step();
    check("scroll mid-frame ignored", int'(rom_address), 10);
    blank = 1'b0; DrawX = 10'd0; DrawY = 10'd480;
    step();
    scroll_x = 7'd5;
    blank = 1'b1; DrawX = 10'd600; DrawY = 10'd0;
    step();
    check("scroll 50 wrap addr", int'(rom_address), 44);
    DrawX = 10'd320; DrawY = 10'd240;
    step();
    check("scroll 50 centre addr", int'(rom_address), 4610);

    // ---- Lookup during blanking ----
    blank = 1'b0; DrawX = 10'd0; DrawY = 10'd490;
    lk_bus.lk_req = 1'b1; lk_bus.lk_x = 7'd5; lk_bus.lk_y = 7'd2;
    step();
    check("lookup addr", int'(rom_address), 197);
    check("lookup ack early 1", int'(lk_bus.lk_ack), 0);
    lk_bus.lk_x = 7'd50;
    step();
    check("lookup ack early 2", int'(lk_bus.lk_ack), 0);
    check("lookup addr held", int'(rom_address), 197);
    step();
    check("lookup ack", int'(lk_bus.lk_ack), 1);
    check("lookup data", int'(lk_bus.lk_data), int'(rom_model(197)));
    lk_bus.lk_req = 1'b0;
    step();
    check("lookup ack pulse end", int'(lk_bus.lk_ack), 0);

    // ---- Abort by video, then retry ----
    lk_bus.lk_req = 1'b1; lk_bus.lk_x = 7'd7; lk_bus.lk_y = 7'd3;
    step();
    check("abort accept addr", int'(rom_address), 295);
    blank = 1'b1; DrawX = 10'd320; DrawY = 10'd240;
    step();
    check("abort video addr", int'(rom_address), 4610);
    check("abort no ack 1", int'(lk_bus.lk_ack), 0);
    step();
    check("abort no ack 2", int'(lk_bus.lk_ack), 0);
    blank = 1'b0; DrawX = 10'd5; DrawY = 10'd490;
    step();
    check("retry addr", int'(rom_address), 295);
    check("retry no ack 1", int'(lk_bus.lk_ack), 0);
    step();
    check("retry no ack 2", int'(lk_bus.lk_ack), 0);
    step();
    check("retry ack", int'(lk_bus.lk_ack), 1);
    check("retry data", int'(lk_bus.lk_data), int'(rom_model(295)));
    lk_bus.lk_req = 1'b0;
    step();
    check("retry ack pulse end", int'(lk_bus.lk_ack), 0);

    // ---- Out-of-range lookups ----
    lk_bus.lk_req = 1'b1; lk_bus.lk_x = 7'd96; lk_bus.lk_y = 7'd0;
    step();
    check("oor x ack", int'(lk_bus.lk_ack), 1);
    check("oor x data", int'(lk_bus.lk_data), 0);
    check("oor x addr unchanged", int'(rom_address), 295);
    lk_bus.lk_req = 1'b0;
    step();
    check("oor x ack end", int'(lk_bus.lk_ack), 0);
    lk_bus.lk_req = 1'b1; lk_bus.lk_x = 7'd0; lk_bus.lk_y = 7'd96;
    step();
    check("oor y ack", int'(lk_bus.lk_ack), 1);
    check("oor y addr unchanged", int'(rom_address), 295);
    lk_bus.lk_req = 1'b0;
    step();

    // ---- Reset mid-lookup drops it ----
    lk_bus.lk_req = 1'b1; lk_bus.lk_x = 7'd1; lk_bus.lk_y = 7'd1;
    step();
    reset_n = 1'b0; lk_bus.lk_req = 1'b0;
    step();
    check("mid-lookup reset addr", int'(rom_address), 0);
    check("mid-lookup reset ack", int'(lk_bus.lk_ack), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("dropped lookup no ack", int'(lk_bus.lk_ack), 0);
    end

    // ---- Randomized traffic against the reference model ----
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    m_addr = 0; m_pix = 0; m_valid = 0; m_ack = 0; m_data = 0;
    m_scroll = 0; m_phase = 0; m_lk_addr = 0; m_blank_d1 = 0;
    blank = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(7) == 0) blank = ~blank;
      if (blank) begin
        DrawX = 10'($urandom_range(639));
        DrawY = 10'($urandom_range(479));
      end else begin
        DrawX = ($urandom_range(3) == 0) ? 10'd0 : 10'($urandom_range(799));
        DrawY = 10'($urandom_range(524, 480));
      end
      scroll_x = 7'($urandom_range(95));
      if (m_ack != 0) begin
        lk_bus.lk_req = 1'b0;
      end else if (!lk_bus.lk_req && $urandom_range(3) == 0) begin
        lk_bus.lk_req = 1'b1;
        lk_bus.lk_x = 7'($urandom_range(104));
        lk_bus.lk_y = 7'($urandom_range(104));
      end else if (lk_bus.lk_req && $urandom_range(15) == 0) begin
        lk_bus.lk_x = 7'($urandom_range(104));
        lk_bus.lk_y = 7'($urandom_range(104));
      end

      // Expected results of the coming edge.
      // m_phase: 0 no lookup in flight, 1 lookup address on the port, 2 lookup data arriving.
      n_ack = 0; n_data = m_data; n_phase = m_phase; n_addr = m_addr; n_lk_addr = m_lk_addr;
      n_valid = m_blank_d1;
      n_pix = (m_blank_d1 != 0) ? int'(rom_model(m_addr)) : 0;
      if (m_phase == 0) begin
        if (lk_bus.lk_req && !blank && m_ack == 0) begin
          if (int'(lk_bus.lk_x) >= TILE_W || int'(lk_bus.lk_y) >= TILE_H) begin
            n_ack = 1;
            n_data = 0;
          end else begin
            n_lk_addr = int'(lk_bus.lk_y) * TILE_W + int'(lk_bus.lk_x);
            n_addr = n_lk_addr;
            n_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        n_phase = blank ? 0 : 2;
      end else begin
        n_ack = 1;
        n_data = int'(rom_model(m_lk_addr));
        n_phase = 0;
      end
      if (blank) n_addr = ref_video(int'(DrawX), int'(DrawY), m_scroll);
      n_scroll = (DrawX == 10'd0 && DrawY == 10'(SCR_H)) ? int'(scroll_x) : m_scroll;

      step();

      m_addr = n_addr; m_pix = n_pix; m_valid = n_valid; m_ack = n_ack; m_data = n_data;
      m_scroll = n_scroll; m_phase = n_phase; m_lk_addr = n_lk_addr; m_blank_d1 = int'(blank);

      check("rand rom_address", int'(rom_address), m_addr);
      check("rand pix_index", int'(pix_index), m_pix);
      check("rand pix_valid", int'(pix_valid), m_valid);
      check("rand lk_ack", int'(lk_bus.lk_ack), m_ack);
      check("rand lk_data", int'(lk_bus.lk_data), m_data);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
